// File: rtl/lsu_seq_if.sv
// Load/store sequencer bus: read/write mux selects, operand and result
// addresses, the read and commit strobes, and the operand/result handshake
// with the compute unit.
//   master : driven by lsu_seq (R_am, W_am, rd_en, rd_addr_a/b, op_valid,
//            wr_en, wr_addr); receives op_ready, res_valid
//   slave  : lsu/compute side of the same signals
interface lsu_seq_if #(
    parameter int ADDR_W = 8
);
    logic [1:0]        R_am;
    logic [1:0]        W_am;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr_a;
    logic [ADDR_W-1:0] rd_addr_b;
    logic              op_valid;
    logic              op_ready;
    logic              res_valid;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;

    modport master (
        output R_am, W_am, rd_en, rd_addr_a, rd_addr_b, op_valid, wr_en, wr_addr,
        input  op_ready, res_valid
    );

    modport slave (
        input  R_am, W_am, rd_en, rd_addr_a, rd_addr_b, op_valid, wr_en, wr_addr,
        output op_ready, res_valid
    );
endinterface

// File: rtl/lsu_seq.sv
// Load/store unit sequencer. For each of cfg_len elements: read an operand
// pair, hand it to compute, wait for the result, commit it to the destination.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   start            begin an operation (sampled only while idle)
//   cfg_*            source/dest selects, operand/result bases, element count
//   bus (master)     lsu/compute side: mux selects, addresses, strobes, handshake
//   busy, done, err  status: busy outside IDLE, one-cycle done, sticky error
module lsu_seq #(
    parameter int ADDR_W      = 8,
    parameter int LEN_W       = 8,
    parameter int RD_LAT      = 2,
    parameter int CMP_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        cfg_src,
    input  logic [1:0]        cfg_dst,
    input  logic [ADDR_W-1:0] cfg_a_base,
    input  logic [ADDR_W-1:0] cfg_b_base,
    input  logic [ADDR_W-1:0] cfg_d_base,
    input  logic [LEN_W-1:0]  cfg_len,
    lsu_seq_if.master         bus,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam int CNT_MAX = (CMP_TIMEOUT > RD_LAT) ? CMP_TIMEOUT : RD_LAT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    // Operand data is valid RD_LAT cycles after the read strobe, so the READ
    // cycle itself counts toward the latency and RWAIT covers the remainder.
    localparam logic [CNT_W-1:0] RWAIT_LAST = CNT_W'((RD_LAT > 1) ? RD_LAT - 2 : 0);
    localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(CMP_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_RWAIT, S_ISSUE, S_CWAIT, S_WRITE, S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [LEN_W-1:0]  idx_q, idx_d, len_q, len_d;
    logic [1:0]        src_q, src_d, dst_q, dst_d;
    logic [ADDR_W-1:0] a_base_q, a_base_d, b_base_q, b_base_d, d_base_q, d_base_d;
    logic [1:0]        r_am_q, r_am_d, w_am_q, w_am_d;
    logic              rd_en_q, rd_en_d, op_valid_q, op_valid_d, wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] rd_addr_a_q, rd_addr_a_d, rd_addr_b_q, rd_addr_b_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic              busy_q, busy_d, done_q, done_d, err_q, err_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        len_d       = len_q;
        src_d       = src_q;
        dst_d       = dst_q;
        a_base_d    = a_base_q;
        b_base_d    = b_base_q;
        d_base_d    = d_base_q;
        err_d       = err_q;
        rd_addr_a_d = rd_addr_a_q;
        rd_addr_b_d = rd_addr_b_q;
        wr_addr_d   = wr_addr_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    src_d    = cfg_src;
                    dst_d    = cfg_dst;
                    a_base_d = cfg_a_base;
                    b_base_d = cfg_b_base;
                    d_base_d = cfg_d_base;
                    len_d    = cfg_len;
                    idx_d    = '0;
                    err_d    = 1'b0;
                    if (cfg_src == 2'b11) begin
                        state_d = S_DONE;
                        err_d   = 1'b1;
                    end else if (cfg_len == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_READ: begin
                cnt_d   = '0;
                state_d = (RD_LAT == 1) ? S_ISSUE : S_RWAIT;
            end
            S_RWAIT: begin
                if (cnt_q == RWAIT_LAST) state_d = S_ISSUE;
                else                     cnt_d   = cnt_q + CNT_W'(1);
            end
            S_ISSUE: begin
                cnt_d = '0;
                if (op_valid_q && bus.op_ready) state_d = S_CWAIT;
            end
            S_CWAIT: begin
                // A result arriving on the limit cycle still wins over the abort.
                if (bus.res_valid) begin
                    state_d = S_WRITE;
                end else if (cnt_q == TO_LAST) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WRITE: begin
                idx_d   = idx_q + LEN_W'(1);
                state_d = (idx_q == len_q - LEN_W'(1)) ? S_DONE : S_READ;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Registered outputs are derived from the next state so they line up
        // with the state they describe.
        rd_en_d    = (state_d == S_READ);
        r_am_d     = (state_d == S_READ) ? src_d : 2'b11;
        op_valid_d = (state_d == S_ISSUE);
        w_am_d     = (state_d == S_WRITE) ? dst_d : w_am_q;
        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_DONE);
        if (state_d == S_READ) begin
            rd_addr_a_d = a_base_d + ADDR_W'(idx_d);
            rd_addr_b_d = b_base_d + ADDR_W'(idx_d);
        end
        // Commit strobe trails WRITE by one cycle, matching the lsu's register
        // stage on data_in_comp; idx_q is still the pre-increment index here.
        wr_en_d = (state_q == S_WRITE);
        if (state_q == S_WRITE) wr_addr_d = d_base_q + ADDR_W'(idx_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            len_q       <= '0;
            src_q       <= '0;
            dst_q       <= '0;
            a_base_q    <= '0;
            b_base_q    <= '0;
            d_base_q    <= '0;
            r_am_q      <= 2'b11;
            w_am_q      <= 2'b10;
            rd_en_q     <= 1'b0;
            op_valid_q  <= 1'b0;
            wr_en_q     <= 1'b0;
            rd_addr_a_q <= '0;
            rd_addr_b_q <= '0;
            wr_addr_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            len_q       <= len_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            a_base_q    <= a_base_d;
            b_base_q    <= b_base_d;
            d_base_q    <= d_base_d;
            r_am_q      <= r_am_d;
            w_am_q      <= w_am_d;
            rd_en_q     <= rd_en_d;
            op_valid_q  <= op_valid_d;
            wr_en_q     <= wr_en_d;
            rd_addr_a_q <= rd_addr_a_d;
            rd_addr_b_q <= rd_addr_b_d;
            wr_addr_q   <= wr_addr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign bus.R_am      = r_am_q;
    assign bus.W_am      = w_am_q;
    assign bus.rd_en     = rd_en_q;
    assign bus.rd_addr_a = rd_addr_a_q;
    assign bus.rd_addr_b = rd_addr_b_q;
    assign bus.op_valid  = op_valid_q;
    assign bus.wr_en     = wr_en_q;
    assign bus.wr_addr   = wr_addr_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;
endmodule

// File: tb/tb_lsu_seq.sv
// Self-checking bench for lsu_seq: expected reads/writes are queued when an
// operation is started and matched as the DUT strobes rd_en / wr_en.
module tb_lsu_seq;
    localparam int ADDR_W = 8, LEN_W = 8, RD_LAT = 2, CMP_TIMEOUT = 255;

    typedef struct packed { logic [7:0] a; logic [7:0] b; logic [1:0] ram; } rd_t;
    typedef struct packed { logic [7:0] addr; logic [1:0] wam; } wr_t;

    logic       clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [1:0] cfg_src = '0, cfg_dst = '0;
    logic [7:0] cfg_a_base = '0, cfg_b_base = '0, cfg_d_base = '0, cfg_len = '0;
    logic       busy, done, err;
    logic       resp_on = 1'b1, hs_r;

    rd_t rd_q[$];
    wr_t wr_q[$];
    int n_pass = 0, n_total = 0, cyc = 0;
    int n_rd, n_wr, n_ram, n_opv, n_hs, n_done, first_rd_cyc, last_opv_cyc, done_cyc;

    lsu_seq_if #(.ADDR_W(ADDR_W)) bus ();

    lsu_seq #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .RD_LAT(RD_LAT), .CMP_TIMEOUT(CMP_TIMEOUT)) dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_src(cfg_src), .cfg_dst(cfg_dst),
        .cfg_a_base(cfg_a_base), .cfg_b_base(cfg_b_base), .cfg_d_base(cfg_d_base),
        .cfg_len(cfg_len), .bus(bus), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Compute model: result valid the cycle after an accepted operand pair.
    always @(posedge clk) begin
        hs_r = bus.op_valid && bus.op_ready;
        #1 bus.res_valid = hs_r && resp_on;
    end

    // Scoreboard and event counters.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.rd_en) begin
                rd_t e;
                if (n_rd == 0) first_rd_cyc = cyc;
                n_rd++;
                n_total++;
                if (rd_q.size() == 0) $display("FAIL rd_unexpected got a=%h b=%h R_am=%b exp no read", bus.rd_addr_a, bus.rd_addr_b, bus.R_am);
                else begin
                    e = rd_q.pop_front();
                    if ({bus.rd_addr_a, bus.rd_addr_b, bus.R_am} !== e)
                        $display("FAIL rd_match got a=%h b=%h R_am=%b exp a=%h b=%h R_am=%b", bus.rd_addr_a, bus.rd_addr_b, bus.R_am, e.a, e.b, e.ram);
                    else n_pass++;
                end
            end
            if (bus.wr_en) begin
                wr_t e;
                n_wr++;
                n_total++;
                if (wr_q.size() == 0) $display("FAIL wr_unexpected got addr=%h W_am=%b exp no write", bus.wr_addr, bus.W_am);
                else begin
                    e = wr_q.pop_front();
                    if ({bus.wr_addr, bus.W_am} !== e)
                        $display("FAIL wr_match got addr=%h W_am=%b exp addr=%h W_am=%b", bus.wr_addr, bus.W_am, e.addr, e.wam);
                    else n_pass++;
                end
            end
            if (bus.R_am !== 2'b11) n_ram++;
            if (bus.op_valid) begin
                n_opv++;
                last_opv_cyc = cyc;
                if (bus.op_ready) n_hs++;
            end
            if (done) begin
                n_done++;
                done_cyc = cyc;
            end
        end
    end

    task automatic clear_mon();
        n_rd = 0; n_wr = 0; n_ram = 0; n_opv = 0; n_hs = 0; n_done = 0;
        first_rd_cyc = 0; last_opv_cyc = 0; done_cyc = 0;
    endtask

    task automatic start_op(input logic [1:0] src, input logic [1:0] dst, input logic [7:0] a,
                            input logic [7:0] b, input logic [7:0] d, input logic [7:0] len,
                            input int nrd, input int nwr);
        for (int i = 0; i < nrd; i++) rd_q.push_back('{a: a + 8'(i), b: b + 8'(i), ram: src});
        for (int i = 0; i < nwr; i++) wr_q.push_back('{addr: d + 8'(i), wam: dst});
        @(posedge clk); #1;
        cfg_src = src; cfg_dst = dst; cfg_a_base = a; cfg_b_base = b; cfg_d_base = d; cfg_len = len;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin ok = 1'b1; break; end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_total++; if (bus.R_am !== 2'b11) $display("FAIL rst_R_am got %b exp 11", bus.R_am); else n_pass++;
        n_total++; if (bus.W_am !== 2'b10) $display("FAIL rst_W_am got %b exp 10", bus.W_am); else n_pass++;
        n_total++; if ({bus.rd_en, bus.op_valid, bus.wr_en, busy, done, err} !== 6'b0)
            $display("FAIL rst_ctrl got %b exp 000000", {bus.rd_en, bus.op_valid, bus.wr_en, busy, done, err}); else n_pass++;
        n_total++; if ({bus.rd_addr_a, bus.rd_addr_b, bus.wr_addr} !== 24'h0)
            $display("FAIL rst_addr got %h exp 000000", {bus.rd_addr_a, bus.rd_addr_b, bus.wr_addr}); else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_single();
        bit ok;
        clear_mon();
        start_op(2'b00, 2'b01, 8'h10, 8'h20, 8'h30, 8'd1, 1, 1);
        wait_done(50, ok);
        n_total++; if (!ok) $display("FAIL single_done got timeout exp done"); else n_pass++;
        n_total++; if (n_rd != 1 || n_wr != 1) $display("FAIL single_counts got rd=%0d wr=%0d exp rd=1 wr=1", n_rd, n_wr); else n_pass++;
        n_total++; if (n_ram != 1) $display("FAIL single_R_am_cycles got %0d exp 1", n_ram); else n_pass++;
        n_total++; if (err !== 1'b0) $display("FAIL single_err got %b exp 0", err); else n_pass++;
    endtask

    task automatic test_back_to_back();
        bit ok;
        clear_mon();
        start_op(2'b01, 2'b10, 8'h40, 8'h80, 8'hFE, 8'd4, 4, 4);
        repeat (6) @(posedge clk);
        #1;
        cfg_len = 8'd9; cfg_d_base = 8'h00; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(100, ok);
        n_total++; if (!ok) $display("FAIL b2b_done got timeout exp done"); else n_pass++;
        n_total++; if (n_rd != 4 || n_wr != 4) $display("FAIL b2b_counts got rd=%0d wr=%0d exp rd=4 wr=4", n_rd, n_wr); else n_pass++;
        n_total++; if (done_cyc - first_rd_cyc != 20) $display("FAIL b2b_cycles got %0d exp 20", done_cyc - first_rd_cyc); else n_pass++;
        @(negedge clk);
        n_total++; if (busy !== 1'b0) $display("FAIL b2b_busy_after_done got %b exp 0", busy); else n_pass++;
        repeat (5) @(negedge clk);
        #1;
        n_total++; if (n_done != 1 || n_rd != 4) $display("FAIL b2b_no_restart got done=%0d rd=%0d exp done=1 rd=4", n_done, n_rd); else n_pass++;
    endtask

    task automatic test_stall();
        bit ok, seen;
        clear_mon();
        bus.op_ready = 1'b0;
        start_op(2'b00, 2'b00, 8'h05, 8'h06, 8'h07, 8'd1, 1, 1);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.op_valid) begin seen = 1'b1; break; end
        end
        n_total++; if (!seen) $display("FAIL stall_op_valid got timeout exp op_valid"); else n_pass++;
        repeat (5) @(negedge clk);
        n_total++; if ({bus.rd_addr_a, bus.rd_addr_b} !== 16'h0506) $display("FAIL stall_addr got %h exp 0506", {bus.rd_addr_a, bus.rd_addr_b}); else n_pass++;
        bus.op_ready = 1'b1;
        wait_done(50, ok);
        n_total++; if (!ok) $display("FAIL stall_done got timeout exp done"); else n_pass++;
        n_total++; if (n_opv != 6) $display("FAIL stall_op_valid_cycles got %0d exp 6", n_opv); else n_pass++;
        n_total++; if (err !== 1'b0 || n_wr != 1) $display("FAIL stall_result got err=%b wr=%0d exp err=0 wr=1", err, n_wr); else n_pass++;
    endtask

    task automatic test_timeout();
        bit ok;
        clear_mon();
        resp_on = 1'b0;
        start_op(2'b00, 2'b01, 8'h11, 8'h22, 8'h33, 8'd1, 1, 0);
        wait_done(400, ok);
        n_total++; if (!ok) $display("FAIL to_done got timeout exp done"); else n_pass++;
        n_total++; if (err !== 1'b1) $display("FAIL to_err got %b exp 1", err); else n_pass++;
        n_total++; if (done_cyc - last_opv_cyc != CMP_TIMEOUT + 1)
            $display("FAIL to_cwait_cycles got %0d exp %0d", done_cyc - last_opv_cyc - 1, CMP_TIMEOUT); else n_pass++;
        n_total++; if (n_wr != 0) $display("FAIL to_no_write got %0d exp 0", n_wr); else n_pass++;
        repeat (3) @(negedge clk);
        n_total++; if (err !== 1'b1) $display("FAIL to_err_sticky got %b exp 1", err); else n_pass++;
        resp_on = 1'b1;
        clear_mon();
        start_op(2'b00, 2'b01, 8'h11, 8'h22, 8'h33, 8'd1, 1, 1);
        @(negedge clk);
        n_total++; if (err !== 1'b0) $display("FAIL to_err_cleared got %b exp 0", err); else n_pass++;
        wait_done(50, ok);
        n_total++; if (!ok || n_wr != 1) $display("FAIL to_rerun got ok=%b wr=%0d exp ok=1 wr=1", ok, n_wr); else n_pass++;
    endtask

    task automatic test_edge();
        bit ok;
        clear_mon();
        start_op(2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'd0, 0, 0);
        wait_done(20, ok);
        n_total++; if (!ok) $display("FAIL len0_done got timeout exp done"); else n_pass++;
        n_total++; if (n_rd != 0 || n_wr != 0 || err !== 1'b0)
            $display("FAIL len0_quiet got rd=%0d wr=%0d err=%b exp rd=0 wr=0 err=0", n_rd, n_wr, err); else n_pass++;
        clear_mon();
        start_op(2'b11, 2'b00, 8'h01, 8'h02, 8'h03, 8'd3, 0, 0);
        wait_done(20, ok);
        n_total++; if (!ok) $display("FAIL src11_done got timeout exp done"); else n_pass++;
        n_total++; if (err !== 1'b1 || n_rd != 0) $display("FAIL src11_err got err=%b rd=%0d exp err=1 rd=0", err, n_rd); else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit ok;
        clear_mon();
        resp_on = 1'b1;
        start_op(2'b00, 2'b01, 8'h50, 8'h60, 8'h70, 8'd4, 2, 1);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk); #1;
            if (n_wr == 1) begin ok = 1'b1; break; end
        end
        resp_on = 1'b0;
        for (int i = 0; i < 50 && ok; i++) begin
            @(negedge clk); #1;
            if (n_hs == 2) break;
            if (i == 49) ok = 1'b0;
        end
        n_total++; if (!ok) $display("FAIL rmid_reach_cwait got timeout exp second issue"); else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_total++; if ({bus.R_am, bus.W_am} !== 4'b1110) $display("FAIL rmid_mux got %b exp 1110", {bus.R_am, bus.W_am}); else n_pass++;
        n_total++; if ({bus.rd_en, bus.op_valid, bus.wr_en, busy, done, err} !== 6'b0)
            $display("FAIL rmid_ctrl got %b exp 000000", {bus.rd_en, bus.op_valid, bus.wr_en, busy, done, err}); else n_pass++;
        n_total++; if ({bus.rd_addr_a, bus.rd_addr_b, bus.wr_addr} !== 24'h0)
            $display("FAIL rmid_addr got %h exp 000000", {bus.rd_addr_a, bus.rd_addr_b, bus.wr_addr}); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        resp_on = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        n_total++; if (n_done != 0 || n_wr != 1) $display("FAIL rmid_no_done got done=%0d wr=%0d exp done=0 wr=1", n_done, n_wr); else n_pass++;
        clear_mon();
        start_op(2'b00, 2'b01, 8'h50, 8'h60, 8'h70, 8'd4, 4, 4);
        wait_done(100, ok);
        n_total++; if (!ok || n_wr != 4 || err !== 1'b0)
            $display("FAIL rmid_clean_run got ok=%b wr=%0d err=%b exp ok=1 wr=4 err=0", ok, n_wr, err); else n_pass++;
    endtask

    initial begin
        bus.op_ready = 1'b1;
        clear_mon();
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_timeout();
        test_edge();
        test_reset_mid();
        n_total++;
        if (rd_q.size() != 0 || wr_q.size() != 0)
            $display("FAIL scoreboard_drain got rd=%0d wr=%0d exp rd=0 wr=0", rd_q.size(), wr_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
